// File: rtl/watch_key_ctrl_if.sv
// Control bundle from the key sequencer to the watch/stopwatch datapath.
// All signals are registered by the sequencer; the datapath only listens.
interface watch_key_ctrl_if;
   logic [1:0] mode;
   logic [1:0] set_digit;
   logic       set_inc;
   logic       tmr_run;
   logic       tmr_clr;

   modport master (output mode, output set_digit, output set_inc, output tmr_run, output tmr_clr);
   modport slave  (input  mode, input  set_digit, input  set_inc, input  tmr_run, input  tmr_clr);
endinterface

// File: rtl/watch_key_ctrl.sv
// Key sequencer: sync + debounce two keys, classify short/long/chord, drive mode FSM.
// Latency: raw edge to debounced flip 2+DEBOUNCE_CYC cycles, event to output 1 cycle; no backpressure.
module watch_key_ctrl #(
   parameter int CLK_HZ          = 50_000_000,
   parameter int DEBOUNCE_CYC    = CLK_HZ / 50,
   parameter int LONG_CYC        = CLK_HZ,
   parameter int SET_TIMEOUT_CYC = CLK_HZ * 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_1_n,
   input  logic key_2_n,
   watch_key_ctrl_if.master ctl
);
   localparam int DBW = $clog2(DEBOUNCE_CYC) + 1;
   localparam int HW  = $clog2(LONG_CYC) + 1;
   localparam int IW  = $clog2(SET_TIMEOUT_CYC) + 1;

   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0]  LONG_MAX  = HW'(LONG_CYC);
   localparam logic [HW-1:0]  LONG_M1   = HW'(LONG_CYC - 1);
   localparam logic [IW-1:0]  IDLE_LAST = IW'(SET_TIMEOUT_CYC - 1);

   localparam logic [1:0] ST_WATCH = 2'd0;
   localparam logic [1:0] ST_SET   = 2'd1;
   localparam logic [1:0] ST_TIMER = 2'd2;

   logic [1:0]     sync_a, sync_b;
   logic [1:0]     pk;
   logic [1:0]     db;
   logic [1:0]     armed;
   logic [1:0]     kp, kp_q, rel;
   logic [DBW-1:0] db_cnt [2];
   logic [HW-1:0]  hold_cnt;
   logic           chord;
   logic [IW-1:0]  idle_cnt;

   logic [1:0] state;
   logic [1:0] set_digit;
   logic       set_inc, tmr_run, tmr_clr;

   logic hold_hit, chord_now;
   logic k1_short, k2_short, k1_long, k2_long, chord_long, any_evt;

   // Synchroniser resets to "pressed" so a key held through reset never looks
   // released, which keeps it unarmed until a real release is observed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 2'b00;
         sync_b <= 2'b00;
      end else begin
         sync_a <= {key_2_n, key_1_n};
         sync_b <= sync_a;
      end
   end

   assign pk = ~sync_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db    <= 2'b00;
         armed <= 2'b00;
         kp_q  <= 2'b00;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         kp_q <= kp;
         for (int i = 0; i < 2; i++) begin
            if (pk[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= pk[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
            if (!db[i] && !pk[i]) armed[i] <= 1'b1;
         end
      end
   end

   assign kp  = db & armed;
   assign rel = kp_q & ~kp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         chord    <= 1'b0;
      end else begin
         if (kp == 2'b00) begin
            hold_cnt <= '0;
            chord    <= 1'b0;
         end else begin
            if (hold_cnt != LONG_MAX) hold_cnt <= hold_cnt + 1'b1;
            if (kp == 2'b11) chord <= 1'b1;
         end
      end
   end

   // Hold saturates at LONG_CYC, so the long events and the short-release
   // qualification (hold below LONG_CYC) each happen at most once per press.
   assign hold_hit   = (kp != 2'b00) && (hold_cnt == LONG_M1);
   assign chord_now  = chord | (&kp);
   assign k1_long    = hold_hit & kp[0] & ~chord_now;
   assign k2_long    = hold_hit & kp[1] & ~chord_now;
   assign chord_long = hold_hit & chord_now;
   assign k1_short   = rel[0] & (hold_cnt != LONG_MAX) & ~chord;
   assign k2_short   = rel[1] & (hold_cnt != LONG_MAX) & ~chord;
   assign any_evt    = k1_short | k2_short | k1_long | k2_long | chord_long;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_WATCH;
         set_digit <= 2'd0;
         set_inc   <= 1'b0;
         tmr_run   <= 1'b0;
         tmr_clr   <= 1'b0;
         idle_cnt  <= '0;
      end else begin
         set_inc <= 1'b0;
         tmr_clr <= 1'b0;
         case (state)
            ST_WATCH: begin
               if (k1_long) begin
                  state <= ST_TIMER;
               end else if (chord_long) begin
                  state     <= ST_SET;
                  set_digit <= 2'd0;
                  idle_cnt  <= '0;
               end
            end
            ST_SET: begin
               if (k1_long || chord_long) begin
                  state <= ST_WATCH;
               end else if (!any_evt && idle_cnt == IDLE_LAST) begin
                  state <= ST_WATCH;
               end else begin
                  if (k1_short) set_digit <= set_digit + 2'd1;
                  if (k2_short) set_inc <= 1'b1;
                  idle_cnt <= any_evt ? '0 : idle_cnt + 1'b1;
               end
            end
            ST_TIMER: begin
               if (k1_long) begin
                  state   <= ST_WATCH;
                  tmr_run <= 1'b0;
               end else if (k1_short) begin
                  tmr_clr <= 1'b1;
                  tmr_run <= 1'b0;
               end else if (k2_short) begin
                  tmr_run <= ~tmr_run;
               end
            end
            default: begin
               state   <= ST_WATCH;
               tmr_run <= 1'b0;
            end
         endcase
      end
   end

   assign ctl.mode      = state;
   assign ctl.set_digit = set_digit;
   assign ctl.set_inc   = set_inc;
   assign ctl.tmr_run   = tmr_run;
   assign ctl.tmr_clr   = tmr_clr;
endmodule

// File: tb/tb_watch_key_ctrl.sv
// Directed bench for watch_key_ctrl with short debounce/long/timeout constants.
module tb_watch_key_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_1_n = 1'b1;
   logic key_2_n = 1'b1;

   always #5 clk = ~clk;

   watch_key_ctrl_if ctl();

   watch_key_ctrl #(
      .CLK_HZ(200), .DEBOUNCE_CYC(4), .LONG_CYC(20), .SET_TIMEOUT_CYC(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_1_n(key_1_n), .key_2_n(key_2_n), .ctl(ctl)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_inc = 0, n_clr = 0, n_both = 0, n_clr_run = 0, n_chg = 0;
   logic [1:0] mode_q = 2'd0;

   // Strobe and mode-change tallies, sampled on the inactive edge.
   always @(negedge clk) begin
      if (ctl.set_inc) n_inc++;
      if (ctl.tmr_clr) n_clr++;
      if (ctl.set_inc && ctl.tmr_clr) n_both++;
      if (ctl.tmr_clr && ctl.tmr_run) n_clr_run++;
      if (ctl.mode != mode_q) n_chg++;
      mode_q = ctl.mode;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input bit k1, input bit k2, input int hold, input int after);
      if (k1) key_1_n = 1'b0;
      if (k2) key_2_n = 1'b0;
      cyc(hold);
      key_1_n = 1'b1;
      key_2_n = 1'b1;
      cyc(after);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cyc(3);
      n_cmp++; if (ctl.mode !== 2'd0) begin n_bad++; $display("FAIL rst_mode got %0d want 0", ctl.mode); end
      n_cmp++; if (ctl.set_digit !== 2'd0) begin n_bad++; $display("FAIL rst_digit got %0d want 0", ctl.set_digit); end
      n_cmp++; if (ctl.set_inc !== 1'b0) begin n_bad++; $display("FAIL rst_inc got %0b want 0", ctl.set_inc); end
      n_cmp++; if (ctl.tmr_run !== 1'b0) begin n_bad++; $display("FAIL rst_run got %0b want 0", ctl.tmr_run); end
      n_cmp++; if (ctl.tmr_clr !== 1'b0) begin n_bad++; $display("FAIL rst_clr got %0b want 0", ctl.tmr_clr); end
      rst_n = 1'b1;
      cyc(10);
      n_cmp++; if (ctl.mode !== 2'd0) begin n_bad++; $display("FAIL post_rst_mode got %0d want 0", ctl.mode); end
   endtask

   task automatic test_long_enter;
      int b_chg, b_clr;
      b_chg = n_chg; b_clr = n_clr;
      press(1, 0, 40, 20);
      n_cmp++; if (ctl.mode !== 2'd2) begin n_bad++; $display("FAIL long_enter_mode got %0d want 2", ctl.mode); end
      n_cmp++; if (n_chg - b_chg !== 1) begin n_bad++; $display("FAIL long_enter_changes got %0d want 1", n_chg - b_chg); end
      n_cmp++; if (n_clr - b_clr !== 0) begin n_bad++; $display("FAIL long_release_short got %0d clr want 0", n_clr - b_clr); end
   endtask

   task automatic test_bounce;
      int b_clr;
      b_clr = n_clr;
      for (int i = 0; i < 15; i++) begin
         key_2_n = ~key_2_n;
         cyc(2);
      end
      key_2_n = 1'b1;
      cyc(20);
      n_cmp++; if (ctl.tmr_run !== 1'b0) begin n_bad++; $display("FAIL bounce_run got %0b want 0", ctl.tmr_run); end
      n_cmp++; if (n_clr - b_clr !== 0) begin n_bad++; $display("FAIL bounce_clr got %0d want 0", n_clr - b_clr); end
      n_cmp++; if (ctl.mode !== 2'd2) begin n_bad++; $display("FAIL bounce_mode got %0d want 2", ctl.mode); end
   endtask

   task automatic test_run_clear;
      int b_clr, b_cr;
      press(0, 1, 8, 20);
      n_cmp++; if (ctl.tmr_run !== 1'b1) begin n_bad++; $display("FAIL run_start got %0b want 1", ctl.tmr_run); end
      b_clr = n_clr; b_cr = n_clr_run;
      press(1, 0, 8, 20);
      n_cmp++; if (n_clr - b_clr !== 1) begin n_bad++; $display("FAIL clr_pulses got %0d want 1", n_clr - b_clr); end
      n_cmp++; if (n_clr_run - b_cr !== 0) begin n_bad++; $display("FAIL clr_with_run got %0d want 0", n_clr_run - b_cr); end
      n_cmp++; if (ctl.tmr_run !== 1'b0) begin n_bad++; $display("FAIL run_after_clr got %0b want 0", ctl.tmr_run); end
   endtask

   task automatic test_long_exit;
      int b_clr;
      press(0, 1, 8, 20);
      n_cmp++; if (ctl.tmr_run !== 1'b1) begin n_bad++; $display("FAIL run_before_exit got %0b want 1", ctl.tmr_run); end
      b_clr = n_clr;
      press(1, 0, 40, 20);
      n_cmp++; if (ctl.mode !== 2'd0) begin n_bad++; $display("FAIL long_exit_mode got %0d want 0", ctl.mode); end
      n_cmp++; if (ctl.tmr_run !== 1'b0) begin n_bad++; $display("FAIL long_exit_run got %0b want 0", ctl.tmr_run); end
      n_cmp++; if (n_clr - b_clr !== 0) begin n_bad++; $display("FAIL long_exit_clr got %0d want 0", n_clr - b_clr); end
   endtask

   task automatic test_set_edit;
      int b_inc;
      logic [1:0] exp_digit;
      press(1, 1, 30, 20);
      n_cmp++; if (ctl.mode !== 2'd1) begin n_bad++; $display("FAIL set_entry_mode got %0d want 1", ctl.mode); end
      n_cmp++; if (ctl.set_digit !== 2'd0) begin n_bad++; $display("FAIL set_entry_digit got %0d want 0", ctl.set_digit); end
      exp_digit = 2'd0;
      for (int i = 0; i < 4; i++) begin
         press(1, 0, 8, 12);
         exp_digit = exp_digit + 2'd1;
         n_cmp++; if (ctl.set_digit !== exp_digit) begin n_bad++; $display("FAIL set_digit_step%0d got %0d want %0d", i, ctl.set_digit, exp_digit); end
      end
      b_inc = n_inc;
      press(0, 1, 8, 12);
      n_cmp++; if (n_inc - b_inc !== 1) begin n_bad++; $display("FAIL set_inc_pulses got %0d want 1", n_inc - b_inc); end
      n_cmp++; if (n_both !== 0) begin n_bad++; $display("FAIL strobe_overlap got %0d want 0", n_both); end
      n_cmp++; if (ctl.mode !== 2'd1) begin n_bad++; $display("FAIL set_still_mode got %0d want 1", ctl.mode); end
   endtask

   task automatic test_timeout;
      int k;
      int te, tx, ti;
      logic [1:0] m100;
      k = 0;
      while (ctl.mode != 2'd0 && k < 150) begin cyc(1); k++; end
      n_cmp++; if (ctl.mode !== 2'd0) begin n_bad++; $display("FAIL timeout_pending got %0d want 0", ctl.mode); end
      for (int run = 0; run < 2; run++) begin
         te = -1; tx = -1; ti = -1; m100 = 2'd3;
         key_1_n = 1'b0; key_2_n = 1'b0;
         for (int t = 0; t < 400 && tx < 0; t++) begin
            if (t == 30) begin key_1_n = 1'b1; key_2_n = 1'b1; end
            if (run == 1 && te >= 0 && t == te + 80) key_2_n = 1'b0;
            if (run == 1 && te >= 0 && t == te + 88) key_2_n = 1'b1;
            cyc(1);
            if (te < 0 && ctl.mode == 2'd1) te = t;
            if (te >= 0 && t == te + 100) m100 = ctl.mode;
            if (run == 1 && ti < 0 && ctl.set_inc) ti = t;
            if (te >= 0 && tx < 0 && ctl.mode == 2'd0) tx = t;
         end
         key_1_n = 1'b1; key_2_n = 1'b1;
         cyc(20);
         if (run == 0) begin
            n_cmp++; if (tx < 0 || te < 0 || tx - te != 100) begin n_bad++; $display("FAIL timeout_len got %0d want 100 (entry %0d exit %0d)", tx - te, te, tx); end
         end else begin
            n_cmp++; if (m100 !== 2'd1) begin n_bad++; $display("FAIL timeout_restart_mode got %0d want 1", m100); end
            n_cmp++; if (ti < 0 || tx < 0 || tx - ti != 100) begin n_bad++; $display("FAIL timeout_after_event got %0d want 100 (inc %0d exit %0d)", tx - ti, ti, tx); end
         end
      end
   endtask

   task automatic test_reset_held;
      int b_chg, b_inc, b_clr;
      rst_n = 1'b0;
      key_1_n = 1'b0;
      cyc(5);
      b_chg = n_chg;
      rst_n = 1'b1;
      cyc(50);
      n_cmp++; if (ctl.mode !== 2'd0) begin n_bad++; $display("FAIL held_rst_mode got %0d want 0", ctl.mode); end
      n_cmp++; if (n_chg - b_chg !== 0) begin n_bad++; $display("FAIL held_rst_changes got %0d want 0", n_chg - b_chg); end
      key_1_n = 1'b1;
      cyc(20);
      press(1, 0, 40, 20);
      n_cmp++; if (ctl.mode !== 2'd2) begin n_bad++; $display("FAIL held_then_long got %0d want 2", ctl.mode); end
      press(0, 1, 8, 20);
      n_cmp++; if (ctl.tmr_run !== 1'b1) begin n_bad++; $display("FAIL mid_rst_run_pre got %0b want 1", ctl.tmr_run); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ctl.mode !== 2'd0) begin n_bad++; $display("FAIL mid_rst_mode got %0d want 0", ctl.mode); end
      n_cmp++; if (ctl.tmr_run !== 1'b0) begin n_bad++; $display("FAIL mid_rst_run got %0b want 0", ctl.tmr_run); end
      cyc(3);
      b_inc = n_inc; b_clr = n_clr;
      rst_n = 1'b1;
      cyc(10);
      n_cmp++; if ((n_inc - b_inc) + (n_clr - b_clr) !== 0) begin n_bad++; $display("FAIL strobe_on_deassert got %0d want 0", (n_inc - b_inc) + (n_clr - b_clr)); end
   endtask

   initial begin
      test_reset();
      test_long_enter();
      test_bounce();
      test_run_clear();
      test_long_exit();
      test_set_edit();
      test_timeout();
      test_reset_held();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t, compared %0d", $time, n_cmp);
      $fatal(1, "watchdog");
   end
endmodule
